// File: rtl/tnn_seq_if.sv
// Valid/ready bundle for the sequential ternary-NN engine: feature input and result output.
// The engine is the slave; the feature producer and the result consumer form the master side.
interface tnn_seq_if #(
  parameter int FEAT_CNT   = 12,
  parameter int FEAT_BITS  = 4,
  parameter int HIDDEN_CNT = 40,
  parameter int CLASS_CNT  = 6
);
  localparam int SUM_BITS = $clog2(HIDDEN_CNT + 1);
  localparam int IDX_BITS = $clog2(CLASS_CNT);

  logic                          in_valid;
  logic                          in_ready;
  logic [FEAT_CNT*FEAT_BITS-1:0] features;
  logic                          out_valid;
  logic                          out_ready;
  logic [IDX_BITS-1:0]           prediction;
  logic [CLASS_CNT*SUM_BITS-1:0] scores;

  modport master (
    output in_valid, features, out_ready,
    input  in_ready, out_valid, prediction, scores
  );

  modport slave (
    input  in_valid, features, out_ready,
    output in_ready, out_valid, prediction, scores
  );
endinterface

// File: rtl/tnn_seq_engine.sv
// Time-multiplexed one-hidden-layer ternary-NN classifier: HIDDEN_PAR hidden neurons per cycle,
// class scores accumulated alongside, then a one-class-per-cycle argmax with a held result.
module tnn_seq_engine #(
  parameter int FEAT_CNT   = 12,
  parameter int FEAT_BITS  = 4,
  parameter int HIDDEN_CNT = 40,
  parameter int HIDDEN_PAR = 8,
  parameter int CLASS_CNT  = 6,
  parameter logic [FEAT_CNT*HIDDEN_CNT-1:0]  W1_POS = '0,
  parameter logic [FEAT_CNT*HIDDEN_CNT-1:0]  W1_NZ  = '0,
  parameter logic [CLASS_CNT*HIDDEN_CNT-1:0] W2_POS = '0,
  parameter logic [CLASS_CNT*HIDDEN_CNT-1:0] W2_NZ  = '0
) (
  input  logic     clk,
  input  logic     rst,
  tnn_seq_if.slave bus
);
  localparam int SUM_BITS = $clog2(HIDDEN_CNT + 1);
  localparam int IDX_BITS = $clog2(CLASS_CNT);
  localparam int GRP_CNT  = HIDDEN_CNT / HIDDEN_PAR;
  localparam int GRP_BITS = (GRP_CNT > 1) ? $clog2(GRP_CNT) : 1;
  localparam int PRE_BITS = $clog2(FEAT_CNT + 1) + FEAT_BITS + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HID  = 2'd1;
  localparam logic [1:0] S_ARG  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]                    state_q, state_d;
  logic [FEAT_CNT*FEAT_BITS-1:0] feat_q, feat_d;
  logic [GRP_BITS-1:0]           grp_q, grp_d;
  logic [SUM_BITS-1:0]           score_q [CLASS_CNT];
  logic [SUM_BITS-1:0]           score_d [CLASS_CNT];
  logic [SUM_BITS-1:0]           score_acc [CLASS_CNT];
  logic [SUM_BITS-1:0]           best_q, best_d;
  logic [IDX_BITS-1:0]           idx_q, idx_d;
  logic [IDX_BITS-1:0]           cnt_q, cnt_d;
  logic                          in_ready_q, in_ready_d;
  logic                          out_valid_q, out_valid_d;
  logic [HIDDEN_PAR-1:0]         hid;
  logic [CLASS_CNT*SUM_BITS-1:0] scores_flat;

  // Hidden activations of the current group; the pre-activation width cannot overflow.
  always_comb begin : hid_eval
    logic signed [PRE_BITS-1:0] pre;
    logic [FEAT_BITS-1:0]       fv;
    int                         h;
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    hid = '0;
    pre = '0;
    fv  = '0;
    h   = 0;
    for (int k = 0; k < HIDDEN_PAR; k++) begin
      h   = int'(grp_q) * HIDDEN_PAR + k;
      pre = '0;
      for (int f = 0; f < FEAT_CNT; f++) begin
        fv = feat_q[f*FEAT_BITS +: FEAT_BITS];
        if (W1_NZ[h*FEAT_CNT+f]) begin
          pre = W1_POS[h*FEAT_CNT+f] ? pre + PRE_BITS'(fv) : pre - PRE_BITS'(fv);
        end
      end
      hid[k] = ~pre[PRE_BITS-1];
    end
  end

  always_comb begin : score_eval
    int h;
    h = 0;
    for (int c = 0; c < CLASS_CNT; c++) begin
      score_acc[c] = score_q[c];
      for (int k = 0; k < HIDDEN_PAR; k++) begin
        h = int'(grp_q) * HIDDEN_PAR + k;
        if (W2_NZ[c*HIDDEN_CNT+h] && (W2_POS[c*HIDDEN_CNT+h] == hid[k])) begin
          score_acc[c] = score_acc[c] + SUM_BITS'(1);
        end
      end
    end
  end

  always_comb begin : fsm_next
    state_d     = state_q;
    feat_d      = feat_q;
    grp_d       = grp_q;
    score_d     = score_q;
    best_d      = best_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          feat_d = bus.features;
          for (int c = 0; c < CLASS_CNT; c++) score_d[c] = '0;
          grp_d      = '0;
          idx_d      = '0;
          in_ready_d = 1'b0;
          state_d    = S_HID;
        end
      end
      S_HID: begin
        score_d = score_acc;
        grp_d   = grp_q + 1'b1;
        // The argmax seed must include the last group's contribution, hence score_acc.
        if (grp_q == GRP_BITS'(GRP_CNT - 1)) begin
          best_d  = score_acc[0];
          idx_d   = '0;
          cnt_d   = IDX_BITS'(1);
          state_d = S_ARG;
        end
      end
      S_ARG: begin
        if (score_q[cnt_q] > best_q) begin
          best_d = score_q[cnt_q];
          idx_d  = cnt_q;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == IDX_BITS'(CLASS_CNT - 1)) begin
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      feat_q      <= '0;
      grp_q       <= '0;
      best_q      <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      // NOTE: the score array is visible on the outputs, so it is reset like any other flop.
      for (int c = 0; c < CLASS_CNT; c++) score_q[c] <= '0;
    end else begin
      state_q     <= state_d;
      feat_q      <= feat_d;
      grp_q       <= grp_d;
      best_q      <= best_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      for (int c = 0; c < CLASS_CNT; c++) score_q[c] <= score_d[c];
    end
  end

  always_comb begin
    scores_flat = '0;
    for (int c = 0; c < CLASS_CNT; c++) scores_flat[c*SUM_BITS +: SUM_BITS] = score_q[c];
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.prediction = idx_q;
  assign bus.scores     = scores_flat;
endmodule

// File: tb/tb_tnn_seq_engine.sv
// Self-checking bench for tnn_seq_engine: directed small-config cases plus randomized vectors on the
// default configuration, all compared against a plain-arithmetic reference classifier.
module tb_tnn_seq_engine;
  localparam int AF = 2, AB = 4, AH = 4, AP = 2, AC = 3, ASB = 3;
  localparam int RF = 12, RB = 4, RH = 40, RP = 8, RC = 6, RSB = 6;
  localparam int NUM_RAND = 2500;

  localparam logic [7:0]  A_W1P = 8'h0F;
  localparam logic [7:0]  A_W1N = 8'hFF;
  localparam logic [11:0] A_W2P = 12'h300;
  localparam logic [11:0] A_W2N = 12'hFFF;

  function automatic logic [479:0] gen_bits(input int unsigned seed);
    logic [479:0] v;
    int unsigned  s;
    v = '0;
    s = seed;
    for (int i = 0; i < 480; i++) begin
      s = s ^ (s << 13);
      s = s ^ (s >> 17);
      s = s ^ (s << 5);
      v[i] = s[9];
    end
    return v;
  endfunction

  localparam logic [479:0] R_W1P = gen_bits(32'h1234_5678);
  localparam logic [479:0] R_W1N = gen_bits(32'h0BAD_CAFE) | gen_bits(32'h0000_5EED);
  localparam logic [479:0] T_W2P = gen_bits(32'h7777_1111);
  localparam logic [479:0] T_W2N = gen_bits(32'h2468_ACE1) | gen_bits(32'h1357_9BDF);
  localparam logic [239:0] R_W2P = T_W2P[239:0];
  localparam logic [239:0] R_W2N = T_W2N[239:0];

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        a_in_valid, a_out_ready;
  logic [7:0]  a_features;
  logic        r_in_valid, r_out_ready;
  logic [47:0] r_features;

  tnn_seq_if #(.FEAT_CNT(AF), .FEAT_BITS(AB), .HIDDEN_CNT(AH), .CLASS_CNT(AC)) ifz ();
  tnn_seq_if #(.FEAT_CNT(AF), .FEAT_BITS(AB), .HIDDEN_CNT(AH), .CLASS_CNT(AC)) ifa ();
  tnn_seq_if #(.FEAT_CNT(RF), .FEAT_BITS(RB), .HIDDEN_CNT(RH), .CLASS_CNT(RC)) ifr ();

  assign ifz.in_valid  = a_in_valid;
  assign ifz.features  = a_features;
  assign ifz.out_ready = a_out_ready;
  assign ifa.in_valid  = a_in_valid;
  assign ifa.features  = a_features;
  assign ifa.out_ready = a_out_ready;
  assign ifr.in_valid  = r_in_valid;
  assign ifr.features  = r_features;
  assign ifr.out_ready = r_out_ready;

  tnn_seq_engine #(.FEAT_CNT(AF), .FEAT_BITS(AB), .HIDDEN_CNT(AH), .HIDDEN_PAR(AP), .CLASS_CNT(AC))
    dut_z (.clk(clk), .rst(rst), .bus(ifz));

  tnn_seq_engine #(.FEAT_CNT(AF), .FEAT_BITS(AB), .HIDDEN_CNT(AH), .HIDDEN_PAR(AP), .CLASS_CNT(AC),
                   .W1_POS(A_W1P), .W1_NZ(A_W1N), .W2_POS(A_W2P), .W2_NZ(A_W2N))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));

  tnn_seq_engine #(.FEAT_CNT(RF), .FEAT_BITS(RB), .HIDDEN_CNT(RH), .HIDDEN_PAR(RP), .CLASS_CNT(RC),
                   .W1_POS(R_W1P), .W1_NZ(R_W1N), .W2_POS(R_W2P), .W2_NZ(R_W2N))
    dut_r (.clk(clk), .rst(rst), .bus(ifr));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference classifier: weighted feature sums, >=0 threshold, match counts, lowest-index argmax.
  function automatic void model(input logic [479:0] w1p, input logic [479:0] w1n,
                                input logic [239:0] w2p, input logic [239:0] w2n,
                                input int nf, input int nb, input int nh, input int nc,
                                input logic [47:0] feats, output int sc[6], output int pred);
    int hid[40];
    int pre, v;
    for (int h = 0; h < nh; h++) begin
      pre = 0;
      for (int f = 0; f < nf; f++) begin
        v = 0;
        for (int b = 0; b < nb; b++) v += int'(feats[f*nb+b]) << b;
        if (w1n[h*nf+f]) pre += w1p[h*nf+f] ? v : -v;
      end
      hid[h] = (pre >= 0) ? 1 : 0;
    end
    for (int c = 0; c < 6; c++) sc[c] = 0;
    for (int c = 0; c < nc; c++)
      for (int h = 0; h < nh; h++)
        if (w2n[c*nh+h] && (int'(w2p[c*nh+h]) == hid[h])) sc[c]++;
    pred = 0;
    for (int c = 1; c < nc; c++) if (sc[c] > sc[pred]) pred = c;
  endfunction

  function automatic logic [63:0] pack(input int sc[6], input int nc, input int sb);
    logic [63:0] v;
    int t;
    v = '0;
    for (int c = 0; c < nc; c++) begin
      t = sc[c];
      for (int b = 0; b < sb; b++) v[c*sb+b] = t[b];
    end
    return v;
  endfunction

  task automatic run_a(input logic [7:0] f, output int lat);
    a_features = f;
    a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    a_features = 8'($urandom);
    lat = 0;
    while (!ifa.out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic finish_a();
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0;
    check("a_valid_drop", 64'(ifa.out_valid), 64'd0);
    check("a_ready_back", 64'(ifa.in_ready), 64'd1);
  endtask

  task automatic check_a_model(input string tag, input logic [7:0] f);
    int sc[6];
    int pred;
    model(480'(A_W1P), 480'(A_W1N), 240'(A_W2P), 240'(A_W2N), AF, AB, AH, AC, 48'(f), sc, pred);
    check({tag, "_a_pred"}, 64'(ifa.prediction), 64'(pred));
    check({tag, "_a_scores"}, 64'(ifa.scores), pack(sc, AC, ASB));
    check({tag, "_z_pred"}, 64'(ifz.prediction), 64'd0);
    check({tag, "_z_scores"}, 64'(ifz.scores), 64'd0);
  endtask

  initial begin
    int          lat, w, hold;
    int          sc[6];
    int          pred;
    logic        seen_ov;
    logic [7:0]  fa;
    logic [47:0] fr;
    logic [63:0] exp_s;

    rst = 1'b1;
    a_in_valid = 1'b0; a_out_ready = 1'b0; a_features = '0;
    r_in_valid = 1'b0; r_out_ready = 1'b0; r_features = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(ifa.in_ready), 64'd1);
    check("rst_out_valid", 64'(ifa.out_valid), 64'd0);
    check("rst_pred", 64'(ifa.prediction), 64'd0);
    check("rst_scores", 64'(ifa.scores), 64'd0);
    check("rst_r_ready", 64'(ifr.in_ready), 64'd1);
    check("rst_r_scores", 64'(ifr.scores), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // All-zero weights: every score zero, tie resolves to class 0.
    run_a({4'd7, 4'd3}, lat);
    check("zero_latency", 64'(lat), 64'd4);
    check("zero_scores", 64'(ifz.scores), 64'd0);
    check("zero_pred", 64'(ifz.prediction), 64'd0);
    check_a_model("t2", {4'd7, 4'd3});
    finish_a();

    // Directed weights: hidden=0011 gives scores {4,2,2}; then hold under backpressure.
    run_a({4'd5, 4'd2}, lat);
    check("dir_latency", 64'(lat), 64'd4);
    check("dir_scores", 64'(ifa.scores), 64'({3'd4, 3'd2, 3'd2}));
    check("dir_pred", 64'(ifa.prediction), 64'd2);
    for (int i = 0; i < 20; i++) begin
      a_in_valid = 1'($urandom_range(0, 1));
      a_features = 8'($urandom);
      @(posedge clk); #1;
      check("bp_valid", 64'(ifa.out_valid), 64'd1);
      check("bp_in_ready", 64'(ifa.in_ready), 64'd0);
      check("bp_scores", 64'(ifa.scores), 64'({3'd4, 3'd2, 3'd2}));
      check("bp_pred", 64'(ifa.prediction), 64'd2);
    end
    a_in_valid = 1'b0;
    finish_a();

    // Reset during the second HID cycle discards the inference.
    a_features = {4'd5, 4'd2};
    a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("mid_rst_ready", 64'(ifa.in_ready), 64'd1);
    check("mid_rst_valid", 64'(ifa.out_valid), 64'd0);
    check("mid_rst_scores", 64'(ifa.scores), 64'd0);
    #1;
    rst = 1'b0;
    seen_ov = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      seen_ov = seen_ov | ifa.out_valid;
    end
    check("mid_rst_no_out", 64'(seen_ov), 64'd0);
    run_a({4'd3, 4'd9}, lat);
    check("post_rst_latency", 64'(lat), 64'd4);
    check_a_model("post_rst", {4'd3, 4'd9});
    finish_a();

    for (int n = 0; n < 20; n++) begin
      fa = 8'($urandom);
      run_a(fa, lat);
      check("a_rand_latency", 64'(lat), 64'd4);
      check_a_model("a_rand", fa);
      finish_a();
    end

    // Randomized vectors on the default configuration with random valid/ready activity.
    for (int n = 0; n < NUM_RAND; n++) begin
      repeat ($urandom_range(0, 2)) begin
        r_out_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      fr = {16'($urandom), $urandom};
      r_features = fr;
      r_in_valid = 1'b1;
      w = 0;
      while (!ifr.in_ready && w < 20) begin
        @(posedge clk); #1;
        w++;
      end
      check("r_accept_wait", 64'(ifr.in_ready), 64'd1);
      @(posedge clk); #1;
      r_in_valid = 1'b0;
      lat = 0;
      while (!ifr.out_valid && lat < 100) begin
        r_in_valid  = 1'($urandom_range(0, 1));
        r_features  = {16'($urandom), $urandom};
        r_out_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        lat++;
      end
      check("r_latency", 64'(lat), 64'd10);
      model(R_W1P, R_W1N, R_W2P, R_W2N, RF, RB, RH, RC, fr, sc, pred);
      exp_s = pack(sc, RC, RSB);
      check("r_pred", 64'(ifr.prediction), 64'(pred));
      check("r_scores", 64'(ifr.scores), exp_s);
      hold = 0;
      while (hold < 50) begin
        r_out_ready = ($urandom_range(0, 3) != 0);
        r_in_valid  = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        if (r_out_ready) break;
        check("r_hold_pred", 64'(ifr.prediction), 64'(pred));
        hold++;
      end
      r_in_valid  = 1'b0;
      r_out_ready = 1'b0;
      check("r_valid_drop", 64'(ifr.out_valid), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
